cache_refill_engine: RTL and testbench
======================================

// Module: cache_refill_engine
// PURPOSE
//  Parametrised miss-refill engine for the I/D caches: accepts one miss, issues an AXI-bridge read request
//  (whole line when cached, one word when uncached), gathers return beats into a line buffer, presents the
//  assembled line to the cache data/tagv write path. Sits between cache miss detection and the read bridge.
// PARAMETERS
//  ADDR_W     32  address width
//  DATA_W     32  beat/word width; power of 2, >=8
//  LINE_WORDS 4   words per line; power of 2, >=2; WI=log2(LINE_WORDS), BO=log2(DATA_W/8)
// PORTS
//  clk          in  1                  clock
//  resetn       in  1                  asynchronous, active-low reset
//  miss_valid   in  1                  miss request
//  miss_addr    in  ADDR_W             miss address
//  miss_uncache in  1                  uncached access
//  miss_ready   out 1                  engine idle, miss accepted when miss_valid&&miss_ready
//  rd_req       out 1                  read request to bridge
//  rd_type      out 3                  3'b100 line, 3'b010 word
//  rd_addr      out ADDR_W             line-aligned (cached) / exact (uncached)
//  rd_rdy       in  1                  bridge accepts rd_req
//  ret_valid    in  1                  return beat valid
//  ret_last     in  1                  final beat
//  ret_data     in  DATA_W             return beat
//  fill_valid   out 1                  assembled line available
//  fill_line    out LINE_WORDS*DATA_W  line; word k at bits [k*DATA_W +: DATA_W]
//  fill_addr    out ADDR_W             captured miss_addr
//  fill_uncache out 1                  captured miss_uncache
//  fill_err     out 1                  beat count mismatch on this refill
//  fill_ready   in  1                  consumer takes line
//  err          out 1                  1-cycle pulse on protocol error
// BEHAVIOUR
//  - Reset (any cycle, incl. mid-refill): state IDLE, beat counter 0, buffer 0; miss_ready=1, all other outputs 0.
//  - FSM: IDLE -(miss_valid)-> REQ -(rd_rdy)-> RECV -(ret_valid&&ret_last)-> DONE -(fill_ready)-> IDLE.
//  - IDLE: capture addr/uncache on accept; rd_req=1 from next cycle, rd_addr/rd_type stable until rd_rdy.
//  - Cached rd_addr = {miss_addr[ADDR_W-1:WI+BO], 0}; uncached rd_addr = miss_addr.
//  - RECV: each ret_valid beat written to word[cnt], cnt++; cnt saturates at LINE_WORDS-1 (later beats overwrite last word).
//  - Expected beats: LINE_WORDS cached, 1 uncached (word 0). ret_last with beat count != expected:
//    err pulses that cycle, fill_err=1 for this line; missing words keep prior (zero-cleared) value.
//  - Buffer and cnt cleared on miss accept.
//  - DONE: fill_valid=1 from cycle after last beat, held with stable data until fill_ready; miss_ready=1 cycle after handshake.
//  - ret_valid in IDLE/REQ/DONE: ignored, err pulses.
//  - miss_valid while busy: not accepted (miss_ready=0), no queueing.
//  - Min latency accept->fill_valid: 2 + LINE_WORDS cycles with rd_rdy=1 and back-to-back beats.
// CONFIGURATION
//  CACHE_REFILL_FWD_EN defined: extra outputs fwd_valid(1), fwd_data(DATA_W); fwd_valid pulses 1 cycle in
//   the cycle the beat for word miss_addr[WI+BO-1:BO] (word 0 if uncached) arrives, fwd_data=ret_data;
//   pulses once per refill even if later beats overwrite that word. Reset value 0.
//  Not defined: ports absent; requested word only available via fill_line.
// TESTING
//  1 cached miss 0x1C34, rd_rdy=1, beats 0xA0..0xA3 last on 4th -> rd_addr 0x1C30, rd_type 100, fill_line {A3,A2,A1,A0}, fill_err 0.
//  2 uncached miss 0xBFAF_8004, one beat 0x55 last -> rd_addr 0xBFAF_8004, rd_type 010, word0 0x55, fill_uncache 1.
//  3 cached miss, ret_last on 3rd beat -> err pulse that cycle, fill_err 1, word3 = 0.
//  4 fill_ready held 0 for 5 cycles, miss_valid=1 -> fill_valid/line stable, miss_ready 0; accept only after fill_ready.
//  5 resetn low during RECV beat 2 -> outputs reset immediately; stray ret_valid afterwards -> ignored, err pulse.
//  6 FWD_EN, miss 0x1C38 -> fwd_valid exactly once on beat 2, fwd_data = beat 2 data.

Source files
------------

// File: rtl/cache_refill_engine.sv
// Miss-refill engine: takes one cache miss, issues a line/word read, gathers beats into a line buffer
// and holds the assembled line for the cache write path. Define CACHE_REFILL_FWD_EN for critical-word forwarding.
module cache_refill_engine #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         miss_valid,
  input  logic [ADDR_W-1:0]            miss_addr,
  input  logic                         miss_uncache,
  output logic                         miss_ready,
  output logic                         rd_req,
  output logic [2:0]                   rd_type,
  output logic [ADDR_W-1:0]            rd_addr,
  input  logic                         rd_rdy,
  input  logic                         ret_valid,
  input  logic                         ret_last,
  input  logic [DATA_W-1:0]            ret_data,
  output logic                         fill_valid,
  output logic [LINE_WORDS*DATA_W-1:0] fill_line,
  output logic [ADDR_W-1:0]            fill_addr,
  output logic                         fill_uncache,
  output logic                         fill_err,
  input  logic                         fill_ready,
  output logic                         err,
`ifdef CACHE_REFILL_FWD_EN
  output logic                         fwd_valid,
  output logic [DATA_W-1:0]            fwd_data,
`endif
  output logic [1:0]                   dbg_state
);

  localparam int WI = $clog2(LINE_WORDS);
  localparam int BO = $clog2(DATA_W / 8);
  localparam int NB = WI + 1;

  // Handshakes: a transfer happens in a cycle where valid && ready are both 1
  // (miss_valid/miss_ready, rd_req/rd_rdy, fill_valid/fill_ready); ret_valid has no back-pressure.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RECV = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                      r_state, w_next;
  logic [ADDR_W-1:0]           r_addr;
  logic                        r_uncache;
  logic [LINE_WORDS*DATA_W-1:0] r_line;
  logic [WI-1:0]               r_cnt;
  logic [NB-1:0]               r_nbeats;
  logic                        r_ferr;
  logic                        w_accept;
  logic                        w_beat;
  logic [NB-1:0]               w_nb_inc;
  logic [NB-1:0]               w_exp;
  logic                        w_mismatch;

  assign w_nb_inc   = r_nbeats + 1'b1;
  assign w_exp      = r_uncache ? NB'(1) : NB'(LINE_WORDS);
  assign w_mismatch = (w_nb_inc != w_exp);

  always_comb begin
    w_next     = r_state;
    miss_ready = 1'b0;
    rd_req     = 1'b0;
    fill_valid = 1'b0;
    w_accept   = 1'b0;
    w_beat     = 1'b0;
    case (r_state)
      S_IDLE: begin
        miss_ready = 1'b1;
        if (miss_valid) begin
          w_accept = 1'b1;
          w_next   = S_REQ;
        end
      end
      S_REQ: begin
        rd_req = 1'b1;
        if (rd_rdy) w_next = S_RECV;
      end
      S_RECV: begin
        if (ret_valid) begin
          w_beat = 1'b1;
          if (ret_last) w_next = S_DONE;
        end
      end
      S_DONE: begin
        fill_valid = 1'b1;
        if (fill_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Beats outside RECV, or a short/long burst ending, flag a protocol error in the same cycle.
  assign err = resetn && ret_valid && ((r_state != S_RECV) || (ret_last && w_mismatch));

  assign rd_type      = rd_req ? (r_uncache ? 3'b010 : 3'b100) : 3'b000;
  assign rd_addr      = !rd_req   ? '0 :
                        r_uncache ? r_addr : {r_addr[ADDR_W-1:WI+BO], {(WI+BO){1'b0}}};
  assign fill_line    = r_line;
  assign fill_addr    = r_addr;
  assign fill_uncache = r_uncache;
  assign fill_err     = r_ferr;
  assign dbg_state    = r_state;

`ifdef CACHE_REFILL_FWD_EN
  logic          r_fwd_done;
  logic [WI-1:0] w_fwd_word;

  assign w_fwd_word = r_uncache ? '0 : r_addr[WI+BO-1:BO];
  assign fwd_valid  = resetn && w_beat && !r_fwd_done && (r_cnt == w_fwd_word);
  assign fwd_data   = fwd_valid ? ret_data : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)            r_fwd_done <= 1'b0;
    else if (w_accept)      r_fwd_done <= 1'b0;
    else if (fwd_valid)     r_fwd_done <= 1'b1;
  end
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_uncache <= 1'b0;
      r_line    <= '0;
      r_cnt     <= '0;
      r_nbeats  <= '0;
      r_ferr    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr    <= miss_addr;
        r_uncache <= miss_uncache;
        r_line    <= '0;
        r_cnt     <= '0;
        r_nbeats  <= '0;
        r_ferr    <= 1'b0;
      end else if (w_beat) begin
        for (int k = 0; k < LINE_WORDS; k++) begin
          if (r_cnt == WI'(k)) r_line[k*DATA_W +: DATA_W] <= ret_data;
        end
        // Counter parks on the last word so overrun beats overwrite it.
        if (r_cnt != WI'(LINE_WORDS-1)) r_cnt <= r_cnt + 1'b1;
        if (r_nbeats != '1) r_nbeats <= w_nb_inc;
        if (ret_last && w_mismatch) r_ferr <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cache_refill_engine.sv
// Directed bench for cache_refill_engine: scoreboard of expected lines, checked at each fill.
module tb_cache_refill_engine;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 4;

  logic            clk = 1'b0;
  logic            resetn;
  logic            miss_valid, miss_uncache, miss_ready;
  logic [AW-1:0]   miss_addr;
  logic            rd_req, rd_rdy;
  logic [2:0]      rd_type;
  logic [AW-1:0]   rd_addr;
  logic            ret_valid, ret_last;
  logic [DW-1:0]   ret_data;
  logic            fill_valid, fill_uncache, fill_err, fill_ready, err;
  logic [LW*DW-1:0] fill_line;
  logic [AW-1:0]   fill_addr;
  logic [1:0]      dbg_state;
`ifdef CACHE_REFILL_FWD_EN
  logic            fwd_valid;
  logic [DW-1:0]   fwd_data;
`endif

  int total = 0;
  int bad   = 0;
  logic [LW*DW-1:0] exp_q[$];
  logic             exp_err_q[$];

  cache_refill_engine #(.ADDR_W(AW), .DATA_W(DW), .LINE_WORDS(LW)) dut (
    .clk(clk), .resetn(resetn),
    .miss_valid(miss_valid), .miss_addr(miss_addr), .miss_uncache(miss_uncache), .miss_ready(miss_ready),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .fill_valid(fill_valid), .fill_line(fill_line), .fill_addr(fill_addr),
    .fill_uncache(fill_uncache), .fill_err(fill_err), .fill_ready(fill_ready), .err(err),
`ifdef CACHE_REFILL_FWD_EN
    .fwd_valid(fwd_valid), .fwd_data(fwd_data),
`endif
    .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LW*DW-1:0] model_line(input int n, input logic [DW-1:0] base);
    logic [LW*DW-1:0] l;
    int k;
    l = '0;
    for (int i = 0; i < n; i++) begin
      k = (i < LW) ? i : LW - 1;
      l[k*DW +: DW] = base + DW'(i);
    end
    return l;
  endfunction

  // Runs one refill up to the DONE state and checks the presented line; leaves fill_ready low.
  task automatic refill(input logic [AW-1:0] a, input logic u, input int n,
                        input logic [DW-1:0] base, input int rd_wait);
    logic [AW-1:0]    e_addr;
    logic [2:0]       e_type;
    logic [LW*DW-1:0] e_line;
    logic             e_ferr;
    logic             e_err;
    int               tgt;
    e_addr = u ? a : {a[AW-1:4], 4'b0000};
    e_type = u ? 3'b010 : 3'b100;
    tgt    = u ? 0 : int'(a[3:2]);
    miss_addr = a; miss_uncache = u; miss_valid = 1'b1;
    #1;
    total++; if (miss_ready !== 1'b1) begin bad++; $error("FAIL miss_ready_idle obs=%0h", miss_ready); end
    tick();
    miss_valid = 1'b0;
    total++; if (dbg_state !== 2'd1) begin bad++; $error("FAIL state_req obs=%0h", dbg_state); end
    for (int w = 0; w < rd_wait; w++) begin
      if (w == 0) begin
        ret_valid = 1'b1; ret_data = 32'hDEAD; #1;
        total++; if (err !== 1'b1) begin bad++; $error("FAIL err_beat_in_req obs=%0h", err); end
        ret_valid = 1'b0;
      end
      total++; if (rd_req !== 1'b1) begin bad++; $error("FAIL rd_req_wait obs=%0h", rd_req); end
      total++; if (rd_addr !== e_addr) begin bad++; $error("FAIL rd_addr_wait obs=%0h exp=%0h", rd_addr, e_addr); end
      tick();
    end
    total++; if (rd_req !== 1'b1) begin bad++; $error("FAIL rd_req obs=%0h", rd_req); end
    total++; if (rd_addr !== e_addr) begin bad++; $error("FAIL rd_addr obs=%0h exp=%0h", rd_addr, e_addr); end
    total++; if (rd_type !== e_type) begin bad++; $error("FAIL rd_type obs=%0h exp=%0h", rd_type, e_type); end
    rd_rdy = 1'b1;
    tick();
    rd_rdy = 1'b0;
    total++; if (rd_req !== 1'b0) begin bad++; $error("FAIL rd_req_drop obs=%0h", rd_req); end
    exp_q.push_back(model_line(n, base));
    exp_err_q.push_back(n != (u ? 1 : LW));
    for (int i = 0; i < n; i++) begin
      ret_valid = 1'b1; ret_last = (i == n - 1); ret_data = base + DW'(i);
      #1;
      e_err = (i == n - 1) && (n != (u ? 1 : LW));
      total++; if (err !== e_err) begin bad++; $error("FAIL err_on_beat obs=%0h exp=%0h", err, e_err); end
`ifdef CACHE_REFILL_FWD_EN
      total++; if (fwd_valid !== (i == tgt)) begin bad++; $error("FAIL fwd_valid obs=%0h beat=%0d", fwd_valid, i); end
      if (i == tgt) begin
        total++; if (fwd_data !== base + DW'(i)) begin bad++; $error("FAIL fwd_data obs=%0h", fwd_data); end
      end
`endif
      tick();
    end
    ret_valid = 1'b0; ret_last = 1'b0;
    total++; if (fill_valid !== 1'b1) begin bad++; $error("FAIL fill_valid_latency obs=%0h", fill_valid); end
    if (exp_q.size() == 0) begin
      total++; if (exp_q.size() !== 1) begin bad++; $error("FAIL scoreboard_empty"); end
    end else begin
      e_line = exp_q.pop_front();
      e_ferr = exp_err_q.pop_front();
      total++; if (fill_line !== e_line) begin bad++; $error("FAIL fill_line obs=%0h exp=%0h", fill_line, e_line); end
      total++; if (fill_err !== e_ferr) begin bad++; $error("FAIL fill_err obs=%0h exp=%0h", fill_err, e_ferr); end
    end
    total++; if (fill_addr !== a) begin bad++; $error("FAIL fill_addr obs=%0h exp=%0h", fill_addr, a); end
    total++; if (fill_uncache !== u) begin bad++; $error("FAIL fill_uncache obs=%0h exp=%0h", fill_uncache, u); end
    total++; if (miss_ready !== 1'b0) begin bad++; $error("FAIL miss_ready_busy obs=%0h", miss_ready); end
  endtask

  task automatic finish_fill();
    fill_ready = 1'b1;
    tick();
    fill_ready = 1'b0;
    total++; if (miss_ready !== 1'b1) begin bad++; $error("FAIL miss_ready_after_fill obs=%0h", miss_ready); end
    total++; if (fill_valid !== 1'b0) begin bad++; $error("FAIL fill_valid_after_fill obs=%0h", fill_valid); end
  endtask

  initial begin
    logic [LW*DW-1:0] hold_line;
    resetn = 1'b0; miss_valid = 1'b0; miss_addr = '0; miss_uncache = 1'b0;
    rd_rdy = 1'b0; ret_valid = 1'b0; ret_last = 1'b0; ret_data = '0; fill_ready = 1'b0;
    #12;
    total++; if (miss_ready !== 1'b1) begin bad++; $error("FAIL rst_miss_ready obs=%0h", miss_ready); end
    total++; if (rd_req !== 1'b0) begin bad++; $error("FAIL rst_rd_req obs=%0h", rd_req); end
    total++; if (fill_valid !== 1'b0) begin bad++; $error("FAIL rst_fill_valid obs=%0h", fill_valid); end
    total++; if (fill_line !== {(LW*DW){1'b0}}) begin bad++; $error("FAIL rst_fill_line obs=%0h", fill_line); end
    total++; if (dbg_state !== 2'd0) begin bad++; $error("FAIL rst_state obs=%0h", dbg_state); end
    tick();
    resetn = 1'b1;
    tick();

    // cached line, in-order beats
    refill(32'h0000_1C34, 1'b0, 4, 32'hA0, 0);
    finish_fill();

    // uncached single word
    refill(32'hBFAF_8004, 1'b1, 1, 32'h55, 0);
    total++; if (fill_line[DW-1:0] !== 32'h55) begin bad++; $error("FAIL uc_word0 obs=%0h", fill_line[DW-1:0]); end
    finish_fill();

    // short burst: last on 3rd beat, rd_rdy delayed two cycles
    refill(32'h0000_2008, 1'b0, 3, 32'hB0, 2);
    total++; if (fill_line[3*DW +: DW] !== 32'h0) begin bad++; $error("FAIL short_word3_zero obs=%0h", fill_line[3*DW +: DW]); end
    finish_fill();

    // consumer stalls with a new miss pending
    refill(32'h0000_3000, 1'b0, 4, 32'hC0, 0);
    hold_line = model_line(4, 32'hC0);
    miss_valid = 1'b1; miss_addr = 32'h0000_4004; miss_uncache = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        ret_valid = 1'b1; ret_data = 32'hBEEF; #1;
        total++; if (err !== 1'b1) begin bad++; $error("FAIL err_beat_in_done obs=%0h", err); end
        ret_valid = 1'b0;
      end
      #1;
      total++; if (fill_valid !== 1'b1) begin bad++; $error("FAIL hold_fill_valid obs=%0h", fill_valid); end
      total++; if (fill_line !== hold_line) begin bad++; $error("FAIL hold_fill_line obs=%0h exp=%0h", fill_line, hold_line); end
      total++; if (miss_ready !== 1'b0) begin bad++; $error("FAIL hold_miss_ready obs=%0h", miss_ready); end
      tick();
    end
    fill_ready = 1'b1;
    tick();
    fill_ready = 1'b0;
    total++; if (miss_ready !== 1'b1) begin bad++; $error("FAIL release_miss_ready obs=%0h", miss_ready); end
    // overrun burst: 6 beats, last word overwritten
    refill(32'h0000_4004, 1'b0, 6, 32'hD0, 0);
    total++; if (fill_line[3*DW +: DW] !== 32'hD5) begin bad++; $error("FAIL overrun_word3 obs=%0h", fill_line[3*DW +: DW]); end
    finish_fill();

    // reset in the middle of a burst
    miss_addr = 32'h0000_5000; miss_uncache = 1'b0; miss_valid = 1'b1;
    tick();
    miss_valid = 1'b0; rd_rdy = 1'b1;
    tick();
    rd_rdy = 1'b0;
    ret_valid = 1'b1; ret_data = 32'h11;
    tick();
    ret_data = 32'h12;
    #1;
    resetn = 1'b0;
    #1;
    total++; if (dbg_state !== 2'd0) begin bad++; $error("FAIL midrst_state obs=%0h", dbg_state); end
    total++; if (miss_ready !== 1'b1) begin bad++; $error("FAIL midrst_miss_ready obs=%0h", miss_ready); end
    total++; if (fill_line !== {(LW*DW){1'b0}}) begin bad++; $error("FAIL midrst_fill_line obs=%0h", fill_line); end
    total++; if (err !== 1'b0) begin bad++; $error("FAIL midrst_err obs=%0h", err); end
    total++; if (rd_type !== 3'b000) begin bad++; $error("FAIL midrst_rd_type obs=%0h", rd_type); end
    ret_valid = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    ret_valid = 1'b1; ret_data = 32'h77;
    #1;
    total++; if (err !== 1'b1) begin bad++; $error("FAIL stray_err obs=%0h", err); end
    tick();
    ret_valid = 1'b0;
    total++; if (dbg_state !== 2'd0) begin bad++; $error("FAIL stray_state obs=%0h", dbg_state); end
    total++; if (fill_valid !== 1'b0) begin bad++; $error("FAIL stray_fill_valid obs=%0h", fill_valid); end

    // requested word 2 of the line (forwarded when enabled)
    refill(32'h0000_1C38, 1'b0, 4, 32'hE0, 0);
    finish_fill();

    $display("test done: total=%0d bad=%0d", total, bad);
    if (bad == 0) $display("PASS");
    else $display("FAIL");
    $finish;
  end
endmodule
